// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
//
// Miss-handling controller between a cache (I- or D-side) and a pipelined main
// memory with a fixed read latency. On a miss it stalls the pipeline, streams
// one read request per cycle for every word of the block, writes each returned
// word into the data array and writes the tag together with the last word.
// Requests and returns are counted independently, so they may overlap freely.
//
// Build option:
//   CACHE_FILL_CRITICAL_FIRST_EN  when defined, requests and data writes start
//                                 at the missed word and wrap around the block
//                                 (critical word first). When undefined the
//                                 block is filled linearly from word 0.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   miss_detected        level miss indication from the tag compare
//   miss_address         byte address of the missing access
//   fsm_busy             pipeline stall request
//   memory_read          one-word read request to main memory
//   memory_address       word-aligned request address
//   memory_data_valid    returned word valid this cycle
//   memory_data_out      returned word
//   write_data_array     data array write strobe
//   data_word_sel        word offset within the block being written
//   fill_data            word being written (memory data passed through)
//   write_tag_array      single-cycle tag write strobe (last word)
//   fill_block_addr      latched block base address
// -----------------------------------------------------------------------------
module cache_fill_fsm #(
   parameter  int WORDS_PER_BLOCK = 8,
   parameter  int ADDR_W          = 16,
   localparam int CW              = $clog2(WORDS_PER_BLOCK)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   output logic              fsm_busy,
   output logic              memory_read,
   output logic [ADDR_W-1:0] memory_address,
   input  logic              memory_data_valid,
   input  logic [15:0]       memory_data_out,
   output logic              write_data_array,
   output logic [CW-1:0]     data_word_sel,
   output logic [15:0]       fill_data,
   output logic              write_tag_array,
   output logic [ADDR_W-1:0] fill_block_addr
);

   // Byte-offset bits inside a block of 16-bit words.
   localparam int          OFF_W  = CW + 1;
   localparam logic [CW:0] NWORDS = (CW+1)'(WORDS_PER_BLOCK);

   typedef enum logic {IDLE, FILL} state_t;

   state_t            r_state;
   logic [CW:0]       r_issue_cnt;
   logic [CW:0]       r_ret_cnt;
   logic [ADDR_W-1:0] r_base;

   logic              w_fill;
   logic              w_issuing;
   logic              w_wr;
   logic              w_last;
   logic [CW-1:0]     w_crit;
   logic [CW-1:0]     w_issue_idx;
   logic [CW-1:0]     w_ret_idx;
   logic              w_unused;

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
   logic [CW-1:0]     r_crit;
   assign w_crit   = r_crit;
   assign w_unused = &{1'b0, miss_address[0]};
`else
   assign w_crit   = '0;
   assign w_unused = &{1'b0, miss_address[OFF_W-1:0]};
`endif

   assign w_fill    = (r_state == FILL);
   assign w_issuing = w_fill && (r_issue_cnt < NWORDS);
   // Counter stays below NWORDS while in FILL; the bound also guards against
   // stray valids once all words are in.
   assign w_wr      = w_fill && memory_data_valid && (r_ret_cnt < NWORDS);
   assign w_last    = w_wr && (r_ret_cnt == NWORDS - 1'b1);

   // Offset addition wraps naturally within CW bits (7 -> 0).
   assign w_issue_idx = r_issue_cnt[CW-1:0] + w_crit;
   assign w_ret_idx   = r_ret_cnt[CW-1:0] + w_crit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_issue_cnt <= '0;
         r_ret_cnt   <= '0;
         r_base      <= '0;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
         r_crit      <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (miss_detected) begin
                  r_state     <= FILL;
                  r_issue_cnt <= '0;
                  r_ret_cnt   <= '0;
                  r_base      <= {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
                  r_crit      <= miss_address[CW:1];
`endif
               end
            end
            FILL: begin
               if (w_issuing) r_issue_cnt <= r_issue_cnt + 1'b1;
               if (w_wr)      r_ret_cnt   <= r_ret_cnt + 1'b1;
               if (w_last)    r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Stall must rise in the very cycle the miss is seen, hence the
   // combinational term; gated by reset so every output is 0 in reset.
   assign fsm_busy         = rst_n & (w_fill | miss_detected);
   assign memory_read      = w_issuing;
   assign memory_address   = w_issuing ? {r_base[ADDR_W-1:OFF_W], w_issue_idx, 1'b0} : '0;
   assign write_data_array = w_wr;
   assign data_word_sel    = w_wr ? w_ret_idx : '0;
   assign fill_data        = w_wr ? memory_data_out : '0;
   assign write_tag_array  = w_last;
   assign fill_block_addr  = r_base;

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller between the pipeline's cache (I-side or D-side) and a pipelined main memory that has a fixed 4-cycle read latency.
- Sits downstream of the MEM/IF memory access point.
- On a cache miss it stalls the pipeline and fetches the full 16-byte block, eight 16-bit words.
- It writes each returned word into the data array, then writes the tag on the last word.

Parameters:
- WORDS_PER_BLOCK, 8: words fetched per miss; must be a power of 2. Sets the counter width, log2 = 3.
- ADDR_W, 16: address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- miss_detected  in  1  tag-compare miss, level, from the cache.
- miss_address  in  16  byte address of the missing access.
- fsm_busy  out  1  pipeline stall request.
- memory_read  out  1  read request to main memory, one word per cycle.
- memory_address  out  16  word-aligned request address.
- memory_data_valid  in  1  returned word is valid this cycle.
- memory_data_out  in  16  returned word.
- write_data_array  out  1  write strobe for the cache data array.
- data_word_sel  out  3  word offset within the block for the current write.
- fill_data  out  16  word to write (memory_data_out passed through).
- write_tag_array  out  1  single-cycle tag write strobe.
- fill_block_addr  out  16  latched block base: {miss_address[15:4], 4'b0}.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE; issue_cnt and ret_cnt clear to 0.
  - fill_block_addr clears to 0.
  - All outputs are 0.
- States: IDLE, FILL.
- IDLE:
  - fsm_busy = miss_detected (combinational), so the stall is raised in the same cycle as the miss.
  - On a clock edge with miss_detected=1: latch the block base, clear both counters, go to FILL.
  - memory_data_valid is ignored in IDLE.
- FILL:
  - fsm_busy=1 every cycle.
  - While issue_cnt<8: memory_read=1, memory_address = {base[15:4], issue_idx, 1'b0}, and issue_cnt increments each cycle.
  - Requests occupy 8 back-to-back cycles; once issue_cnt reaches 8, memory_read=0.
  - Each cycle memory_data_valid=1 (and ret_cnt<8):
    - write_data_array=1.
    - data_word_sel = return index.
    - fill_data = memory_data_out.
    - ret_cnt increments.
  - Returns are counted independently of issues, so overlap of issue and return is legal.
  - On the 8th return: write_tag_array=1 in the same cycle as the last data write, then go to IDLE on the next edge.
  - fsm_busy is 0 in the following cycle unless a new miss is presented.
- Timing, memory latency 4, miss sampled at cycle 0:
  - FILL from cycle 1.
  - Requests in cycles 1–8.
  - Returns in cycles 5–12.
  - Tag write in cycle 12.
  - IDLE at cycle 13.
  - fsm_busy high in cycles 0–12: 13 cycles.
- Boundary conditions:
  - miss_detected while in FILL is ignored; the latched address is unchanged.
  - memory_data_valid after the 8th return is ignored: no write strobe.
  - Reset mid-fill aborts immediately; no tag write occurs. Late returns that arrive after reset are ignored.
  - A miss asserted in the IDLE cycle right after a fill starts a new fill with no idle gap.
  - The block has no timeout: the FSM waits in FILL until 8 returns are seen.
- issue_idx and return index are issue_cnt[2:0] and ret_cnt[2:0]; they are remapped when the optional feature is enabled.

Optional Feature:
- Macro: CACHE_FILL_CRITICAL_FIRST_EN.
- Defined: critical-word-first ordering.
  - issue_idx = (miss_address[3:1] + issue_cnt) mod 8.
  - Return index = (miss_address[3:1] + ret_cnt) mod 8, wrapping 7→0.
  - The first write_data_array carries the missed word.
  - Tag write is still on the 8th return.
- Undefined: linear order starting at word 0; miss_address[3:1] is unused.
- Cycle counts are identical in both builds.

Test Plan:
- Basic fill:
  - Stimulus: reset, then miss_detected=1 with miss_address=16'h1236 for 1 cycle; memory model with latency 4 returns 16'hA000+idx.
  - Required: memory_read asserted cycles 1–8 with addresses 1230,1232,…,123E.
  - Required: data writes in cycles 5–12 with data_word_sel 0..7 and fill_data A000..A007.
  - Required: write_tag_array only in cycle 12; fill_block_addr=16'h1230; fsm_busy drops in cycle 13.
- Stall coverage: fsm_busy=1 in the same cycle miss_detected rises in IDLE; busy is continuous for exactly 13 cycles.
- Ignored inputs:
  - Toggle miss_detected with address 16'h4000 during FILL: fill_block_addr stays 16'h1230.
  - Inject memory_data_valid while in IDLE: no write_data_array.
- Reset mid-fill: deassert rst_n at cycle 7.
  - Required: all outputs go to 0 asynchronously; no tag write.
  - Required: returns at cycles 8–12 produce no writes.
  - Required: a subsequent miss completes normally.
- Back-to-back misses: second miss at 16'h2000 in the cycle after IDLE is re-entered; the second fill starts immediately with requests 2000..200E.
- Critical-first, with CACHE_FILL_CRITICAL_FIRST_EN defined:
  - Stimulus: miss_address=16'h123A.
  - Required: requests 123A,123C,123E,1230,…,1238.
  - Required: data_word_sel sequence 5,6,7,0,1,2,3,4; tag write on the 8th return.
